// File: rtl/pc_seq_pkg.sv
// pc_sequencer shared types: FSM state, width/vector defaults, alignment mask.
// Optional feature macro: PC_SEQ_PERF_EN (adds redirect_cnt).
package pc_seq_pkg;

    localparam int          XLEN_DEF         = 64;
    localparam int          INSTR_BYTES_DEF  = 4;
    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIRECT,
        HALT
    } seq_state_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Request/response bundle between the pipeline control and pc_sequencer.
// Optional feature macro: PC_SEQ_PERF_EN (adds redirect_cnt).
interface pc_seq_if #(
    parameter int XLEN = 64
);

    logic            stall;
    logic            imem_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            trap_req;
    logic [XLEN-1:0] trap_vector;
    logic            halt;

    logic [XLEN-1:0] pc_next;
    logic            fetch_valid;
    logic            flush;
    logic            misalign;
`ifdef PC_SEQ_PERF_EN
    logic [31:0]     redirect_cnt;
`endif

    modport master (
        output stall,
        output imem_ready,
        output branch_taken,
        output branch_target,
        output trap_req,
        output trap_vector,
        output halt,
        input  pc_next,
        input  fetch_valid,
        input  flush,
        input  misalign
`ifdef PC_SEQ_PERF_EN
        , input redirect_cnt
`endif
    );

    modport slave (
        input  stall,
        input  imem_ready,
        input  branch_taken,
        input  branch_target,
        input  trap_req,
        input  trap_vector,
        input  halt,
        output pc_next,
        output fetch_valid,
        output flush,
        output misalign
`ifdef PC_SEQ_PERF_EN
        , output redirect_cnt
`endif
    );

endinterface

// File: rtl/pc_target_mux.sv
// Redirect priority select (trap over branch) with target alignment
// and misalign detection. Purely combinational.
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            trap_req,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            branch_taken,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_target,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] raw;

    always_comb begin
        redirect = 1'b0;
        raw      = '0;
        if (trap_req && trap_en) begin
            redirect = 1'b1;
            raw      = trap_vector;
        end else if (branch_taken && branch_en) begin
            redirect = 1'b1;
            raw      = branch_target;
        end
        target   = {raw[XLEN-1:2], raw[1:0] & ~ALIGN_MASK};
        misalign = redirect && is_misaligned(raw[1:0]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential advance, hold, redirect.
// Optional feature macro: PC_SEQ_PERF_EN (saturating redirect_cnt).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEF
) (
    input logic     clk,
    input logic     reset,
    pc_seq_if.slave bus
);

    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fv_q;
    logic            flush_q;
    logic            mis_q;
    logic            mis_d;

    logic            redir;
    logic [XLEN-1:0] redir_target;
    logic            redir_mis;

    // Branches only count from RUN: in REDIRECT their source is being
    // flushed, in HALT they are ignored. Traps are honoured after BOOT.
    pc_target_mux #(
        .XLEN (XLEN)
    ) u_mux (
        .trap_req      (bus.trap_req),
        .trap_en       (state_q != BOOT),
        .trap_vector   (bus.trap_vector),
        .branch_taken  (bus.branch_taken),
        .branch_en     (state_q == RUN),
        .branch_target (bus.branch_target),
        .redirect      (redir),
        .target        (redir_target),
        .misalign      (redir_mis)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        if (redir) begin
            state_d = REDIRECT;
            pc_d    = redir_target;
            mis_d   = redir_mis;
        end else begin
            unique case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (bus.halt) begin
                        state_d = HALT;
                    end else if (!bus.stall && bus.imem_ready) begin
                        pc_d = pc_q + XLEN'(INSTR_BYTES);
                    end
                end
                REDIRECT: state_d = RUN;
                HALT:     state_d = HALT;
                default:  state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= (state_d == RUN);
            flush_q <= (state_d == REDIRECT);
            mis_q   <= mis_d;
        end
    end

    assign bus.pc_next     = pc_q;
    assign bus.fetch_valid = fv_q;
    assign bus.flush       = flush_q;
    assign bus.misalign    = mis_q;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (redir && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer.
// Define PC_SEQ_PERF_EN to also check redirect_cnt.
module tb_pc_sequencer;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct packed {
        logic [63:0] pc;
        logic        fv;
        logic        fl;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t  sb[$];
    string tags[$];

    pc_seq_if #(.XLEN(XLEN)) bus();

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (64'h0),
        .INSTR_BYTES  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [63:0] pc,
                              input logic fv, input logic fl,
                              input logic mis);
        exp_t e;
        e.pc  = pc;
        e.fv  = fv;
        e.fl  = fl;
        e.mis = mis;
        e.cnt = exp_cnt;
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic check_now();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: empty queue at output sample");
            return;
        end
        e = sb.pop_front();
        t = tags.pop_front();
        checks++;
        assert (bus.pc_next === e.pc) else begin
            errors++;
            $error("FAIL %s pc_next: got %h exp %h", t, bus.pc_next, e.pc);
        end
        checks++;
        assert (bus.fetch_valid === e.fv) else begin
            errors++;
            $error("FAIL %s fetch_valid: got %b exp %b", t, bus.fetch_valid, e.fv);
        end
        checks++;
        assert (bus.flush === e.fl) else begin
            errors++;
            $error("FAIL %s flush: got %b exp %b", t, bus.flush, e.fl);
        end
        checks++;
        assert (bus.misalign === e.mis) else begin
            errors++;
            $error("FAIL %s misalign: got %b exp %b", t, bus.misalign, e.mis);
        end
`ifdef PC_SEQ_PERF_EN
        checks++;
        assert (bus.redirect_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s redirect_cnt: got %0d exp %0d", t, bus.redirect_cnt, e.cnt);
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        bus.stall         = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.trap_req      = 1'b0;
        bus.trap_vector   = '0;
        bus.halt          = 1'b0;

        #3;
        expect_out("rst_hold", 64'h0, 0, 0, 0);
        check_now();
        expect_out("rst_edge", 64'h0, 0, 0, 0);
        step();

        reset = 1'b1;
        expect_out("boot_exit", 64'h0, 1, 0, 0);
        step();
        expect_out("seq4", 64'h4, 1, 0, 0);
        step();
        expect_out("seq8", 64'h8, 1, 0, 0);
        step();

        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h100;
        exp_cnt++;
        expect_out("br_redir", 64'h100, 0, 1, 0);
        step();
        bus.branch_taken = 1'b0;
        expect_out("br_land", 64'h100, 1, 0, 0);
        step();
        expect_out("br_seq", 64'h104, 1, 0, 0);
        step();

        bus.trap_req      = 1'b1;
        bus.trap_vector   = 64'h800;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h200;
        exp_cnt++;
        expect_out("trap_win", 64'h800, 0, 1, 0);
        step();
        bus.branch_taken = 1'b0;
        bus.trap_vector  = 64'h900;
        exp_cnt++;
        expect_out("trap_b2b", 64'h900, 0, 1, 0);
        step();
        bus.trap_req      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h300;
        expect_out("br_in_redir", 64'h900, 1, 0, 0);
        step();
        bus.branch_taken = 1'b0;
        expect_out("trap_seq", 64'h904, 1, 0, 0);
        step();

        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h40;
        exp_cnt++;
        expect_out("br40", 64'h40, 0, 1, 0);
        step();
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b1;
        expect_out("land40", 64'h40, 1, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            expect_out("stall40", 64'h40, 1, 0, 0);
            step();
        end
        bus.stall = 1'b0;
        expect_out("unstall", 64'h44, 1, 0, 0);
        step();
        bus.imem_ready = 1'b0;
        expect_out("imem_wait", 64'h44, 1, 0, 0);
        step();
        bus.imem_ready = 1'b1;
        expect_out("imem_go", 64'h48, 1, 0, 0);
        step();

        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h103;
        exp_cnt++;
        expect_out("mis_redir", 64'h100, 0, 1, 1);
        step();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        expect_out("mis_clear", 64'h100, 1, 0, 0);
        step();

        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'hffff_ffff_ffff_fffc;
        exp_cnt++;
        expect_out("wrap_redir", 64'hffff_ffff_ffff_fffc, 0, 1, 0);
        step();
        bus.branch_taken = 1'b0;
        expect_out("wrap_land", 64'hffff_ffff_ffff_fffc, 1, 0, 0);
        step();
        expect_out("wrap_zero", 64'h0, 1, 0, 0);
        step();

        bus.halt = 1'b1;
        expect_out("halt_enter", 64'h0, 0, 0, 0);
        step();
        bus.halt          = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h300;
        bus.stall         = 1'b1;
        expect_out("halt_br", 64'h0, 0, 0, 0);
        step();
        expect_out("halt_br2", 64'h0, 0, 0, 0);
        step();
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
        expect_out("halt_idle", 64'h0, 0, 0, 0);
        step();

        bus.trap_req    = 1'b1;
        bus.trap_vector = 64'h503;
        exp_cnt++;
        expect_out("halt_trap", 64'h500, 0, 1, 1);
        step();

        bus.trap_req = 1'b0;
        reset        = 1'b0;
        #1;
        exp_cnt = 32'd0;
        expect_out("rst_async", 64'h0, 0, 0, 0);
        check_now();
        expect_out("rst_async_edge", 64'h0, 0, 0, 0);
        step();
        reset = 1'b1;
        expect_out("reboot", 64'h0, 1, 0, 0);
        step();
        expect_out("reboot_seq", 64'h4, 1, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 64-bit fetch stage. It sits in front of the program counter register and decides every cycle whether fetch advances sequentially, holds, or redirects to a branch or trap target. It also generates the IF/ID flush pulse and the fetch-valid qualifier for instruction memory. The existing program counter becomes a plain storage element driven by this block's `pc_next`.

## Interface
- `XLEN`, 64: address width.
- `RESET_VECTOR`, 64'h0: first fetch address after reset.
- `INSTR_BYTES`, 4: sequential increment.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit hold request.
- `imem_ready` in 1: instruction memory accepted the current fetch.
- `branch_taken` in 1: redirect request from EX.
- `branch_target` in XLEN: redirect address.
- `trap_req` in 1: exception or interrupt redirect; has priority over branch.
- `trap_vector` in XLEN: trap handler address.
- `halt` in 1: stop fetching, e.g. on ebreak.
- `pc_next` out XLEN: registered current fetch address, fed to the PC register and imem.
- `fetch_valid` out 1: `pc_next` is a live fetch request.
- `flush` out 1: one-cycle kill of the IF/ID contents.
- `misalign` out 1: one-cycle pulse; a redirect target had bits [1:0] != 0.
- `redirect_cnt` out 32: taken-redirect counter. Present only under `PC_SEQ_PERF_EN`.

## Operation
- FSM states: BOOT, RUN, REDIRECT, HALT.
- BOOT: entered while `reset` is low.
  - `pc_next`=`RESET_VECTOR`; `fetch_valid`, `flush`, `misalign`=0; `redirect_cnt`=0.
  - On the first edge after reset release, go to RUN with the PC unchanged.
- RUN (`fetch_valid`=1). Priority per edge:
  1. `trap_req`: PC := `trap_vector`, go to REDIRECT.
  2. `branch_taken`: PC := `branch_target`, go to REDIRECT.
  3. `halt`: go to HALT, PC held.
  4. `stall` or !`imem_ready`: hold PC.
  5. Otherwise PC := PC + `INSTR_BYTES`, modulo 2^XLEN (wraps ffff_fffc to 0).
- Any redirect target has bits [1:0] forced to 0. If the original bits [1:0] != 0, `misalign` pulses in the REDIRECT cycle.
- REDIRECT: exactly one cycle.
  - `fetch_valid`=0, `flush`=1; `pc_next` already holds the target.
  - `branch_taken` is ignored (its source is being flushed).
  - `trap_req` is honoured: PC := `trap_vector`, stay in REDIRECT one more cycle.
  - Otherwise go to RUN.
- HALT: `fetch_valid`=0 and PC held.
  - `trap_req` takes it to REDIRECT.
  - `branch_taken`, `stall` and `halt` are ignored.
  - Reset also exits HALT.
- Simultaneous `trap_req` and `branch_taken`: trap wins and the branch is dropped.
- Redirect while `stall` is high: the redirect still wins; stall only blocks sequential advance.
- Reset asserted mid-operation: outputs go to BOOT values immediately (asynchronous), regardless of state.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Redirect latency:
  - Request sampled at edge N.
  - After edge N: `pc_next`=target, `flush`=1, `fetch_valid`=0.
  - After edge N+1: `fetch_valid`=1 at the target.
  - Cost: one bubble cycle.
- Sequential advance: the edge after `imem_ready`=1 with no stall presents PC+4.
- `flush` and `misalign` are never high for more than one consecutive cycle, except back-to-back traps.

## Configuration
- `PC_SEQ_PERF_EN`:
  - Defined: `redirect_cnt` exists.
    - Increments by 1 on every edge that enters REDIRECT (branch or trap).
    - Saturates at ffff_ffff.
    - Cleared by reset.
  - Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the state enum (BOOT, RUN, REDIRECT, HALT);
  - `XLEN`, `INSTR_BYTES` and `RESET_VECTOR` defaults;
  - the alignment mask constant.
- One sub-module: `pc_target_mux`, the combinational priority select plus alignment and misalign detect. The FSM and registers stay in `pc_sequencer`.

## Test plan
- Reset release, `imem_ready`=1, no stall, 3 cycles:
  - `pc_next` = 0, then 0, 4, 8.
  - `fetch_valid`=0 during reset, 1 afterwards.
- `branch_taken`=1 with `branch_target`=0x100 while at PC 0x8:
  - Next cycle: `pc_next`=0x100, `flush`=1, `fetch_valid`=0.
  - Following cycle: `fetch_valid`=1 with PC 0x100, then 0x104.
- `trap_req`=1 with `trap_vector`=0x800, together with `branch_taken`=1 and target 0x200:
  - `pc_next`=0x800; `redirect_cnt` +1 only.
- `stall`=1 for 4 cycles at PC 0x40:
  - PC stays 0x40 with `fetch_valid`=1 throughout.
  - Release gives 0x44.
- `branch_target`=0x103: `pc_next`=0x100 and `misalign` pulses once.
- PC at 0xffff_ffff_ffff_fffc advances to 0.
- `halt` then `branch_taken`: PC frozen, `fetch_valid`=0.
- `reset` pulled low mid-REDIRECT: outputs return to BOOT values before the next edge.
